// File: rtl/game_pkg.sv
// Shared game constants and slot encoding.
// Used by the bomb mover and lazer logic.
package game_pkg;

  localparam int COORD_W = 11;

  localparam logic [COORD_W-1:0] PARK_X_DEF   = 11'd1050;
  localparam logic [COORD_W-1:0] PARK_Y_DEF   = 11'd128;
  localparam logic [COORD_W-1:0] STEP_DEF     = 11'd6;
  localparam logic [COORD_W-1:0] Y_BOTTOM_DEF = 11'd1000;

  localparam logic [COORD_W-1:0] SCREEN_W = 11'd1024;
  localparam logic [COORD_W-1:0] SCREEN_H = 11'd1024;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_FALL = 1'b1
  } slot_state_t;

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: idle/fall FSM plus x/y registers.
// Idle slots sit at the park position off screen.
module bomb_slot
  import game_pkg::*;
#(
  parameter logic [COORD_W-1:0] STEP     = STEP_DEF,
  parameter logic [COORD_W-1:0] Y_BOTTOM = Y_BOTTOM_DEF,
  parameter logic [COORD_W-1:0] PARK_X   = PARK_X_DEF,
  parameter logic [COORD_W-1:0] PARK_Y   = PARK_Y_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [COORD_W-1:0] lx,
  input  logic [COORD_W-1:0] ly,
  input  logic               move,
  input  logic               hit,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active
);

  slot_state_t        st_q, st_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  // state and position registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q <= SLOT_IDLE;
      x_q  <= PARK_X;
      y_q  <= PARK_Y;
    end else begin
      st_q <= st_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  // next state: load from idle, fall on move, retire on hit or bottom
  always_comb begin
    st_d = st_q;
    x_d  = x_q;
    y_d  = y_q;
    case (st_q)
      SLOT_IDLE: begin
        x_d = PARK_X;
        y_d = PARK_Y;
        if (load) begin
          st_d = SLOT_FALL;
          x_d  = lx;
          y_d  = ly;
        end
      end
      SLOT_FALL: begin
        if (hit) begin
          st_d = SLOT_IDLE;
          x_d  = PARK_X;
          y_d  = PARK_Y;
        end else if (move) begin
          if (y_q >= Y_BOTTOM) begin
            st_d = SLOT_IDLE;
            x_d  = PARK_X;
            y_d  = PARK_Y;
          end else begin
            y_d = y_q + STEP;
          end
        end
      end
      default: begin
        st_d = SLOT_IDLE;
        x_d  = PARK_X;
        y_d  = PARK_Y;
      end
    endcase
  end

  assign x      = x_q;
  assign y      = y_q;
  assign active = (st_q == SLOT_FALL);

endmodule

// File: rtl/enemy_bomb_mover.sv
// Enemy bomb engine: slot allocator plus NSLOTS falling bombs.
// Optional fire cooldown enabled by BOMB_COOLDOWN_EN.
module enemy_bomb_mover
  import game_pkg::*;
#(
  parameter int                 NSLOTS   = 4,
  parameter logic [COORD_W-1:0] STEP     = STEP_DEF,
  parameter logic [COORD_W-1:0] Y_BOTTOM = Y_BOTTOM_DEF,
  parameter logic [COORD_W-1:0] PARK_X   = PARK_X_DEF,
  parameter logic [COORD_W-1:0] PARK_Y   = PARK_Y_DEF
`ifdef BOMB_COOLDOWN_EN
  ,
  parameter logic [3:0]         COOLDOWN = 4'd8
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      move,
  input  logic                      fire,
  input  logic [COORD_W-1:0]        inx,
  input  logic [COORD_W-1:0]        iny,
  input  logic [NSLOTS-1:0]         hit,
  output logic [NSLOTS*COORD_W-1:0] ox,
  output logic [NSLOTS*COORD_W-1:0] oy,
  output logic [NSLOTS-1:0]         active,
  output logic                      full,
  output logic                      fire_ack
);

  logic [NSLOTS-1:0] load_pri;
  logic [NSLOTS-1:0] load;
  logic              found;
  logic              cd_ok;
  logic              accept;

  // lowest-index idle slot, from registered slot state
  always_comb begin
    load_pri = '0;
    found    = 1'b0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (!active[i] && !found) begin
        load_pri[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign full   = &active;
  assign accept = fire & found & cd_ok;
  assign load   = accept ? load_pri : '0;

`ifdef BOMB_COOLDOWN_EN
  logic [3:0] cd_q;

  // cooldown: reload on accepted fire, count down on frame ticks
  always_ff @(posedge clk) begin
    if (!rst) begin
      cd_q <= 4'd0;
    end else if (accept) begin
      cd_q <= COOLDOWN;
    end else if (move && cd_q != 4'd0) begin
      cd_q <= cd_q - 4'd1;
    end
  end

  assign cd_ok = (cd_q == 4'd0);
`else
  assign cd_ok = 1'b1;
`endif

  // acknowledge lines up with the new slot going active
  always_ff @(posedge clk) begin
    if (!rst) begin
      fire_ack <= 1'b0;
    end else begin
      fire_ack <= accept;
    end
  end

  for (genvar i = 0; i < NSLOTS; i++) begin : g_slot
    bomb_slot #(
      .STEP     (STEP),
      .Y_BOTTOM (Y_BOTTOM),
      .PARK_X   (PARK_X),
      .PARK_Y   (PARK_Y)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .load   (load[i]),
      .lx     (inx),
      .ly     (iny),
      .move   (move),
      .hit    (hit[i]),
      .x      (ox[COORD_W*i +: COORD_W]),
      .y      (oy[COORD_W*i +: COORD_W]),
      .active (active[i])
    );
  end

endmodule

// File: tb/tb_enemy_bomb_mover.sv
// Bench for enemy_bomb_mover: directed steps plus random
// traffic against a slot-level behavioural model.
module tb_enemy_bomb_mover;

  localparam int NS = 4;
  localparam int CW = 11;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           move = 1'b0;
  logic           fire = 1'b0;
  logic [CW-1:0]  inx = '0;
  logic [CW-1:0]  iny = '0;
  logic [NS-1:0]  hit = '0;
  logic [NS*CW-1:0] ox, oy;
  logic [NS-1:0]  active;
  logic           full;
  logic           fire_ack;

  int total = 0;
  int bad   = 0;

  logic [CW-1:0] mx [NS];
  logic [CW-1:0] my [NS];
  logic          ma [NS];
  logic          mack;
  int            mcd;

  always #5 clk = ~clk;

  enemy_bomb_mover #(.NSLOTS(NS)) dut (
    .clk      (clk),
    .rst      (rst),
    .move     (move),
    .fire     (fire),
    .inx      (inx),
    .iny      (iny),
    .hit      (hit),
    .ox       (ox),
    .oy       (oy),
    .active   (active),
    .full     (full),
    .fire_ack (fire_ack)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic park(int i);
    ma[i] = 1'b0;
    mx[i] = 11'd1050;
    my[i] = 11'd128;
  endtask

  task automatic model(logic r, logic f, logic m, logic [NS-1:0] h,
                       logic [CW-1:0] x, logic [CW-1:0] y);
    int  free;
    bit  acc;
    if (!r) begin
      for (int i = 0; i < NS; i++) park(i);
      mack = 1'b0;
      mcd  = 0;
      return;
    end
    free = -1;
    for (int i = NS - 1; i >= 0; i--) if (!ma[i]) free = i;
    acc = f && (free >= 0);
`ifdef BOMB_COOLDOWN_EN
    acc = acc && (mcd == 0);
`endif
    for (int i = 0; i < NS; i++) begin
      if (ma[i]) begin
        if (h[i]) park(i);
        else if (m) begin
          if (my[i] >= 1000) park(i);
          else my[i] = my[i] + 11'd6;
        end
      end else if (acc && i == free) begin
        ma[i] = 1'b1;
        mx[i] = x;
        my[i] = y;
      end
    end
    if (acc) mcd = 8;
    else if (m && mcd > 0) mcd--;
    mack = acc;
  endtask

  task automatic compare(string tag);
    logic [NS*CW-1:0] ex, ey;
    logic [NS-1:0]    ea;
    for (int i = 0; i < NS; i++) begin
      ex[CW*i +: CW] = mx[i];
      ey[CW*i +: CW] = my[i];
      ea[i]          = ma[i];
    end
    chk({tag, ".ox"}, 64'(ox), 64'(ex));
    chk({tag, ".oy"}, 64'(oy), 64'(ey));
    chk({tag, ".active"}, 64'(active), 64'(ea));
    chk({tag, ".full"}, 64'(full), 64'(&ea));
    chk({tag, ".ack"}, 64'(fire_ack), 64'(mack));
  endtask

  task automatic step(string tag, logic r, logic f, logic m,
                      logic [NS-1:0] h, logic [CW-1:0] x, logic [CW-1:0] y);
    rst  = r;
    fire = f;
    move = m;
    hit  = h;
    inx  = x;
    iny  = y;
    @(posedge clk);
    model(r, f, m, h, x, y);
    #1;
    compare(tag);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) park(i);
    mack = 1'b0;
    mcd  = 0;
    #1;

    step("rst0", 0, 0, 0, '0, 0, 0);
    step("rst1", 0, 0, 0, '0, 0, 0);
    chk("rst.ox", 64'(ox), 64'({NS{11'd1050}}));
    chk("rst.oy", 64'(oy), 64'({NS{11'd128}}));
    chk("rst.active", 64'(active), 64'd0);
    chk("rst.ack", 64'(fire_ack), 64'd0);
    chk("rst.full", 64'(full), 64'd0);

    step("fire1", 1, 1, 0, '0, 11'd300, 11'd200);
    chk("fire1.x0", 64'(ox[10:0]), 64'd300);
    chk("fire1.y0", 64'(oy[10:0]), 64'd200);
    chk("fire1.a0", 64'(active[0]), 64'd1);
    chk("fire1.ack", 64'(fire_ack), 64'd1);
    for (int k = 0; k < 3; k++) step("mv3", 1, 0, 1, '0, 0, 0);
    chk("mv3.y0", 64'(oy[10:0]), 64'd218);
    chk("mv3.x0", 64'(ox[10:0]), 64'd300);

`ifndef BOMB_COOLDOWN_EN
    step("rstA", 0, 0, 0, '0, 0, 0);
    for (int k = 0; k < 4; k++)
      step("fill", 1, 1, 0, '0, 11'(100 + k), 11'(50 + k));
    chk("fill.full", 64'(full), 64'd1);
    chk("fill.active", 64'(active), 64'hf);
    step("fire5", 1, 1, 0, '0, 11'd7, 11'd7);
    chk("fire5.ack", 64'(fire_ack), 64'd0);
    chk("fire5.x3", 64'(ox[43:33]), 64'd103);

    step("rstB", 0, 0, 0, '0, 0, 0);
    step("hfa", 1, 1, 0, '0, 11'd10, 11'd100);
    step("hfb", 1, 1, 0, '0, 11'd20, 11'd500);
    step("hitmv", 1, 0, 1, 4'b0010, 0, 0);
    chk("hit.a1", 64'(active[1]), 64'd0);
    chk("hit.y1", 64'(oy[21:11]), 64'd128);
    chk("hit.y0", 64'(oy[10:0]), 64'd106);
`endif

    step("rstC", 0, 0, 0, '0, 0, 0);
    step("btm", 1, 1, 0, '0, 11'd40, 11'd996);
    step("btm1", 1, 0, 1, '0, 0, 0);
    chk("btm1.y0", 64'(oy[10:0]), 64'd1002);
    step("btm2", 1, 0, 1, '0, 0, 0);
    chk("btm2.y0", 64'(oy[10:0]), 64'd128);
    chk("btm2.a0", 64'(active[0]), 64'd0);

`ifdef BOMB_COOLDOWN_EN
    step("rstD", 0, 0, 0, '0, 0, 0);
    step("cd0", 1, 1, 0, '0, 11'd60, 11'd10);
    chk("cd0.ack", 64'(fire_ack), 64'd1);
    for (int k = 0; k < 7; k++) step("cdmv", 1, 0, 1, '0, 0, 0);
    step("cd7", 1, 1, 0, '0, 11'd61, 11'd11);
    chk("cd7.ack", 64'(fire_ack), 64'd0);
    step("cdmv8", 1, 0, 1, '0, 0, 0);
    step("cd8", 1, 1, 0, '0, 11'd62, 11'd12);
    chk("cd8.ack", 64'(fire_ack), 64'd1);
`endif

    for (int k = 0; k < 600; k++) begin
      logic          r, f, m;
      logic [NS-1:0] h;
      r = ($urandom_range(0, 99) != 0);
      f = ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 1) == 0);
      h = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
      step("rnd", r, f, m, h, 11'($urandom_range(0, 1023)),
           11'($urandom_range(0, 1010)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
